// File: rtl/nitta_i2c_tx_arbiter_if.sv
// Bundle of requester-side and I2C-byte-side signals for the transmit arbiter.
// master = arbiter side, slave = requesters plus the I2C byte sink.
// No state; timing and backpressure are defined by the arbiter.
interface nitta_i2c_tx_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int REQ_NUM        = 4
);
    localparam int GRANT_W = $clog2(REQ_NUM);

    logic [REQ_NUM-1:0]            req_valid;
    logic [REQ_NUM*DATA_WIDTH-1:0] req_data;
    logic [REQ_NUM-1:0]            req_ready;
    logic [I2C_DATA_WIDTH-1:0]     to_i2c;
    logic                          i2c_valid;
    logic                          i2c_ready;
    logic                          busy;
    logic [GRANT_W-1:0]            grant_id;

    modport master (
        input  req_valid, req_data, i2c_ready,
        output req_ready, to_i2c, i2c_valid, busy, grant_id
    );

    modport slave (
        output req_valid, req_data, i2c_ready,
        input  req_ready, to_i2c, i2c_valid, busy, grant_id
    );
endinterface

// File: rtl/nitta_i2c_tx_arbiter.sv
// Round-robin arbiter serialising NITTA words from REQ_NUM sources onto one I2C byte stream.
// Latency: grant (req_ready) in cycle t, first byte valid in t+1; one idle bubble between words.
// Backpressure: bytes are registered and held stable while i2c_ready is low; requests wait in IDLE.
module nitta_i2c_tx_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int REQ_NUM        = 4,
    parameter int SEND_HEADER    = 1
) (
    input logic                     clk,
    input logic                     rst,
    nitta_i2c_tx_arbiter_if.master  bus
);
    localparam int SUBFRAME_NUMBER = DATA_WIDTH / I2C_DATA_WIDTH;
    localparam int CNT_W           = (SUBFRAME_NUMBER > 1) ? $clog2(SUBFRAME_NUMBER) : 1;
    localparam int GRANT_W         = $clog2(REQ_NUM);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t                    state_q, state_n;
    logic [DATA_WIDTH-1:0]     shreg_q, shreg_n, shifted;
    logic [CNT_W-1:0]          cnt_q, cnt_n;
    logic [GRANT_W-1:0]        grant_q, grant_n, last_q, last_n;
    logic [I2C_DATA_WIDTH-1:0] byte_q, byte_n;
    logic                      valid_q, valid_n;
    logic [REQ_NUM-1:0]        ready_c;
    logic [GRANT_W-1:0]        pick, cand;
    logic                      found;
    logic [DATA_WIDTH-1:0]     pick_word;
    int                        idx;

    // Scan starting just after the last served source so it has lowest priority.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        cand      = '0;
        idx       = 0;
        pick_word = '0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            idx  = (int'(last_q) + k) % REQ_NUM;
            cand = GRANT_W'(idx);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        for (int i = 0; i < REQ_NUM; i++) begin
            if (pick == GRANT_W'(i)) pick_word = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_n = state_q;
        shreg_n = shreg_q;
        cnt_n   = cnt_q;
        grant_n = grant_q;
        last_n  = last_q;
        byte_n  = byte_q;
        valid_n = valid_q;
        ready_c = '0;
        shifted = shreg_q << I2C_DATA_WIDTH;
        case (state_q)
            IDLE: begin
                if (found) begin
                    ready_c[pick] = 1'b1;
                    grant_n       = pick;
                    shreg_n       = pick_word;
                    cnt_n         = '0;
                    valid_n       = 1'b1;
                    if (SEND_HEADER != 0) begin
                        state_n = HEADER;
                        byte_n  = I2C_DATA_WIDTH'(pick);
                    end else begin
                        state_n = DATA;
                        byte_n  = pick_word[DATA_WIDTH-1 -: I2C_DATA_WIDTH];
                    end
                end
            end
            HEADER: begin
                if (bus.i2c_ready) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    byte_n  = shreg_q[DATA_WIDTH-1 -: I2C_DATA_WIDTH];
                end
            end
            DATA: begin
                if (bus.i2c_ready) begin
                    shreg_n = shifted;
                    byte_n  = shifted[DATA_WIDTH-1 -: I2C_DATA_WIDTH];
                    if (cnt_q == CNT_W'(SUBFRAME_NUMBER - 1)) begin
                        state_n = IDLE;
                        last_n  = grant_q;
                        cnt_n   = '0;
                        valid_n = 1'b0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            last_q  <= GRANT_W'(REQ_NUM - 1);
            byte_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            shreg_q <= shreg_n;
            cnt_q   <= cnt_n;
            grant_q <= grant_n;
            last_q  <= last_n;
            byte_q  <= byte_n;
            valid_q <= valid_n;
        end
    end

    // Accept strobe is combinational from the scan, so mask it while reset is held.
    assign bus.req_ready = rst ? ready_c : '0;
    assign bus.to_i2c    = byte_q;
    assign bus.i2c_valid = valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant_id  = grant_q;
endmodule

// File: tb/tb_nitta_i2c_tx_arbiter.sv
// Directed and random checks of the I2C transmit arbiter against a queue-based byte model.
module tb_nitta_i2c_tx_arbiter;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    nitta_i2c_tx_arbiter_if #(.DATA_WIDTH(32), .I2C_DATA_WIDTH(8), .REQ_NUM(4)) if_a();
    nitta_i2c_tx_arbiter_if #(.DATA_WIDTH(16), .I2C_DATA_WIDTH(8), .REQ_NUM(4)) if_b();

    nitta_i2c_tx_arbiter #(.DATA_WIDTH(32), .I2C_DATA_WIDTH(8), .REQ_NUM(4), .SEND_HEADER(1))
        dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
    nitta_i2c_tx_arbiter #(.DATA_WIDTH(16), .I2C_DATA_WIDTH(8), .REQ_NUM(4), .SEND_HEADER(0))
        dut_b (.clk(clk), .rst(rst_b), .bus(if_b));

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // Model of DUT A: expected byte stream of the word in flight plus round-robin pointer.
    logic [7:0] exp_q[$];
    int         lg_m;
    int         cur_g;
    logic       prev_stall;
    logic [7:0] prev_byte;
    int         grant_log[$];
    logic [7:0] acc_log[$];
    int         acc_cyc[$];
    logic [7:0] b_log[$];
    int         b_cyc[$];
    int         b_grants = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int lg);
        int i;
        for (int k = 1; k <= 4; k++) begin
            i = (lg + k) % 4;
            if (v[i[1:0]]) return i;
        end
        return -1;
    endfunction

    task automatic set_word_a(input int i, input logic [31:0] w);
        if_a.req_data[i*32 +: 32] = w;
    endtask

    task automatic cyc();
        logic [31:0] word;
        @(negedge clk);
        cyc_n++;
        if (rst_a) begin
            if (exp_q.size() == 0) begin
                int g;
                g = rr_pick(if_a.req_valid, lg_m);
                chk("busy_idle", 64'(if_a.busy), 64'd0);
                if (g < 0) begin
                    chk("ready_none", 64'(if_a.req_ready), 64'd0);
                end else begin
                    chk("ready_grant", 64'(if_a.req_ready), 64'd1 << g);
                    cur_g = g;
                    lg_m  = g;
                    grant_log.push_back(g);
                    word = if_a.req_data[g*32 +: 32];
                    exp_q.push_back(8'(g));
                    for (int b = 3; b >= 0; b--) exp_q.push_back(word[b*8 +: 8]);
                end
                prev_stall = 1'b0;
            end else begin
                chk("busy_active", 64'(if_a.busy), 64'd1);
                chk("ready_quiet", 64'(if_a.req_ready), 64'd0);
                chk("valid_active", 64'(if_a.i2c_valid), 64'd1);
                if (prev_stall) chk("stall_stable", 64'(if_a.to_i2c), 64'(prev_byte));
                if (if_a.i2c_ready) begin
                    chk("byte", 64'(if_a.to_i2c), 64'(exp_q.pop_front()));
                    chk("grant_id", 64'(if_a.grant_id), 64'(cur_g));
                    acc_log.push_back(if_a.to_i2c);
                    acc_cyc.push_back(cyc_n);
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_byte  = if_a.to_i2c;
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
        if (if_b.i2c_valid && if_b.i2c_ready) begin
            b_log.push_back(if_b.to_i2c);
            b_cyc.push_back(cyc_n);
        end
        if (if_b.req_ready != 4'd0) b_grants++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        repeat (2) cyc();
        rst_a = 1'b1;
        exp_q.delete();
        lg_m       = 3;
        prev_stall = 1'b0;
    endtask

    task automatic drain_a(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc();
        cyc();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] want[$]);
        chk(tag, 64'(got.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++) chk(tag, 64'(got[i]), 64'(want[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        if_a.req_valid = 4'hF;
        if_a.req_data  = '0;
        if_a.i2c_ready = 1'b1;
        if_b.req_valid = 4'h0;
        if_b.req_data  = '0;
        if_b.i2c_ready = 1'b1;
        lg_m = 3;
        cur_g = 0;
        prev_stall = 1'b0;
        prev_byte = '0;
        repeat (3) cyc();
        chk("rst_busy", 64'(if_a.busy), 64'd0);
        chk("rst_valid", 64'(if_a.i2c_valid), 64'd0);
        chk("rst_to_i2c", 64'(if_a.to_i2c), 64'd0);
        chk("rst_grant_id", 64'(if_a.grant_id), 64'd0);
        chk("rst_req_ready", 64'(if_a.req_ready), 64'd0);
        if_a.req_valid = 4'h0;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Single word
        acc_log.delete(); acc_cyc.delete();
        set_word_a(0, 32'hDEADBEEF);
        if_a.req_valid = 4'b0001;
        cyc();
        if_a.req_valid = 4'b0000;
        repeat (6) cyc();
        chk_bytes("single_bytes", acc_log, '{8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
        if (acc_cyc.size() == 5) chk("single_back_to_back", 64'(acc_cyc[4] - acc_cyc[0]), 64'd4);
        chk("single_busy_after", 64'(if_a.busy), 64'd0);

        // Round-robin with all sources held
        reset_a();
        grant_log.delete();
        set_word_a(0, 32'h11111111); set_word_a(1, 32'h22222222);
        set_word_a(2, 32'h33333333); set_word_a(3, 32'h44444444);
        if_a.req_valid = 4'hF;
        repeat (30) cyc();
        if_a.req_valid = 4'h0;
        drain_a("rr_drain");
        chk("rr_count", 64'(grant_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_order", 64'(grant_log[i]), 64'(i % 4));

        // Backpressure: three stall cycles before each acceptance
        reset_a();
        acc_log.delete(); acc_cyc.delete();
        set_word_a(0, 32'h0A0B0C0D);
        if_a.i2c_ready = 1'b0;
        if_a.req_valid = 4'b0001;
        cyc();
        if_a.req_valid = 4'b0000;
        for (int n = 0; n < 5; n++) begin
            if_a.i2c_ready = 1'b0;
            repeat (3) cyc();
            if_a.i2c_ready = 1'b1;
            cyc();
        end
        cyc();
        chk_bytes("bp_bytes", acc_log, '{8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h0D});
        for (int i = 1; i < acc_cyc.size(); i++) chk("bp_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd4);

        // Fairness after a skipped source
        reset_a();
        if_a.req_valid = 4'b0010;
        cyc();
        if_a.req_valid = 4'b0000;
        repeat (5) cyc();
        grant_log.delete();
        if_a.req_valid = 4'b0101;
        cyc();
        if_a.req_valid = 4'b0001;
        repeat (6) cyc();
        if_a.req_valid = 4'b0000;
        drain_a("fair_drain");
        chk("fair_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() >= 2) begin
            chk("fair_first", 64'(grant_log[0]), 64'd2);
            chk("fair_second", 64'(grant_log[1]), 64'd0);
        end

        // Headerless 16-bit variant, back-to-back words
        b_log.delete(); b_cyc.delete(); b_grants = 0;
        if_b.req_data[15:0] = 16'hBEEF;
        if_b.req_valid = 4'b0001;
        cyc();
        if_b.req_data[15:0] = 16'h1234;
        repeat (3) cyc();
        if_b.req_valid = 4'b0000;
        repeat (3) cyc();
        chk_bytes("b_bytes", b_log, '{8'hBE, 8'hEF, 8'h12, 8'h34});
        chk("b_grants", 64'(b_grants), 64'd2);
        if (b_cyc.size() == 4) begin
            chk("b_consecutive", 64'(b_cyc[1] - b_cyc[0]), 64'd1);
            chk("b_bubble", 64'(b_cyc[2] - b_cyc[1]), 64'd2);
        end

        // Reset after the second data byte
        reset_a();
        set_word_a(0, 32'h55667788);
        if_a.req_valid = 4'b0001;
        cyc();
        if_a.req_valid = 4'b0000;
        repeat (3) cyc();
        rst_a = 1'b0;
        if_a.i2c_ready = 1'b0;
        if_a.req_valid = 4'b0001;
        exp_q.delete();
        cyc();
        chk("midrst_valid", 64'(if_a.i2c_valid), 64'd0);
        chk("midrst_busy", 64'(if_a.busy), 64'd0);
        chk("midrst_ready", 64'(if_a.req_ready), 64'd0);
        rst_a = 1'b1;
        lg_m = 3;
        prev_stall = 1'b0;
        if_a.i2c_ready = 1'b1;
        acc_log.delete();
        cyc();
        if_a.req_valid = 4'b0000;
        repeat (6) cyc();
        chk("midrst_count", 64'(acc_log.size()), 64'd5);
        if (acc_log.size() > 0) chk("midrst_header", 64'(acc_log[0]), 64'd0);

        // Random traffic, model tracks grants and bytes
        reset_a();
        grant_log.delete();
        for (int n = 0; n < 3000; n++) begin
            if_a.req_valid = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            for (int s = 0; s < 4; s++) set_word_a(s, $urandom);
            if_a.i2c_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        if_a.req_valid = 4'h0;
        if_a.i2c_ready = 1'b1;
        drain_a("rand_drain");
        total++;
        assert (grant_log.size() > 50) else begin
            bad++;
            $error("FAIL rand_grants observed=%0d expected=>50", grant_log.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
